// File: rtl/lasd_pkg.sv
// Shared types and helpers for the hex digit source: nibble type, run/stop
// state encoding and the modulo-16 step used by the digit register.
package lasd_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  localparam nibble_t NIBBLE_MAX = 4'hF;

  // Next digit value for one count step, wrapping modulo 16.
  function automatic nibble_t step_nibble(input nibble_t d, input logic up);
    return up ? nibble_t'(d + 4'd1) : nibble_t'(d - 4'd1);
  endfunction

  // True when a count step from d in the given direction crosses the wrap point.
  function automatic logic step_wraps(input nibble_t d, input logic up);
    return up ? (d == NIBBLE_MAX) : (d == nibble_t'(0));
  endfunction

endpackage

// File: rtl/hex_digit_source_key_debouncer.sv
// Pushbutton conditioning: 2-flop synchronizer, stability counter, debounced
// level and a single-cycle registered press pulse on the 1->0 level change.
module key_debouncer
  import lasd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          key_p0;
  logic          key_p1;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  // Synchronize the raw key, count disagreement with the accepted level and
  // flip the level once it has been contradicted for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0  <= 1'b1;
      key_p1  <= 1'b1;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter
      key_p0 <= key_n;
      key_p1 <= key_p0;
      // stage p1 -> level: stability counter
      if (key_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= key_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // stage level -> press: falling edge of the debounced level only
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

// File: rtl/hex_digit_source.sv
// Single hex digit source for the 7-segment decoder. The digit is loaded from
// switches on a debounced key press and counts up/down on prescaler ticks
// while the run switch is on.
module hex_digit_source
  import lasd_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  nibble_t load_val,
  input  logic    load_key_n,
  input  logic    run,
  input  logic    up_dn,
  output nibble_t digit,
  output logic    wrap,
  output logic    tick,
  output logic    running
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("hex_digit_source: CLK_HZ/TICK_HZ must be at least 2");
  end

  if (DEBOUNCE_CYCLES < 1) begin : g_db_check
    $error("hex_digit_source: DEBOUNCE_CYCLES must be at least 1");
  end

  logic          press;
  logic          run_p0;
  logic          run_p1;
  logic          updn_p0;
  logic          updn_p1;
  logic [PW-1:0] presc;
  run_state_t    state;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (load_key_n),
    .press (press)
  );

  // Bring the run and direction switches into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_p0  <= 1'b0;
      run_p1  <= 1'b0;
      updn_p0 <= 1'b0;
      updn_p1 <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter
      run_p0  <= run;
      run_p1  <= run_p0;
      updn_p0 <= up_dn;
      updn_p1 <= updn_p0;
    end
  end

  assign tick = (presc == PW'(DIV - 1));

  // Free-running prescaler; a load restarts it so the next count is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (press || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Run/stop state machine following the synchronized run switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STOP;
      running <= 1'b0;
    end else begin
      case (state)
        STOP: if (run_p1) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: if (!run_p1) begin
          state   <= STOP;
          running <= 1'b0;
        end
        default: begin
          state   <= STOP;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Digit register: load has priority over a count step on a coinciding tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
      wrap  <= 1'b0;
    end else if (press) begin
      digit <= load_val;
      wrap  <= 1'b0;
    end else if ((state == RUN) && tick) begin
      digit <= step_nibble(digit, updn_p1);
      wrap  <= step_wraps(digit, updn_p1);
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule
